// File: rtl/full_stage_error_ctrl.sv
// Error-feedback controller for one network stage: counts incoming error beats,
// tracks buffered error blocks and sequences the tap-update latch/first controls.
module full_stage_error_ctrl #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PHASES     = 4,
  parameter int WR_HOLD    = 4,
  parameter int LATCH_HOLD = 6,
  parameter int MODE_DLY   = 2,
  localparam int PH_W      = $clog2(PHASES),
  localparam int DEPTH_W   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [CNT_W-1:0]   error_tap_length,
  input  logic [CNT_W-1:0]   load_length,
  input  logic               state_finish,
  input  logic               read_finish,
  input  logic [DATA_W-1:0]  stage_error,
  input  logic               stage_error_vld,
  input  logic               stage_error_fst,
  output logic               stage_error_rdy,
  output logic               error_valid,
  output logic [DATA_W-1:0]  error_value,
  output logic [CNT_W-1:0]   error_count,
  output logic [CNT_W-1:0]   error_sub_address,
  output logic [PH_W-1:0]    error_phase,
  output logic [PH_W-1:0]    error_phase_read,
  output logic [DEPTH_W-1:0] error_fifo_depth,
  output logic               error_update_mode,
  output logic               error_update_latch,
  output logic               error_update_first,
  output logic               error_finish_tap,
  output logic               stage_error_mode,
  output logic               stage_error_first,
  output logic               error_frame_err
);

  localparam int                 LAT_LEN   = (LATCH_HOLD > MODE_DLY) ? LATCH_HOLD : MODE_DLY;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(PHASES - 1);

  logic               accept;
  logic               error_finish;
  logic               full;
  logic               wr_address_vld;
  logic               release_q;
  logic               first_q;
  logic [WR_HOLD:1]   wr_vld_d;
  logic [LAT_LEN:1]   latch_d;
  logic [MODE_DLY:1]  first_d;

  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + PH_W'(1);
  endfunction

  assign full               = (error_fifo_depth == DEPTH_MAX);
  assign error_update_mode  = (error_fifo_depth != '0);
  assign error_update_first = first_q & error_update_latch;
  assign wr_address_vld     = error_update_latch & ~error_update_first;

  // Ready looks only at the delayed latch/write-address taps, so a fresh
  // update blocks the stream a fixed number of cycles later.
  assign stage_error_rdy = ~wr_vld_d[WR_HOLD] & ~full & ~latch_d[LATCH_HOLD] & ~flush;

  assign accept       = stage_error_vld & stage_error_rdy;
  assign error_valid  = accept;
  assign error_value  = stage_error;
  assign error_finish = accept & (error_count == error_tap_length);

  assign error_finish_tap  = state_finish & error_update_latch;
  assign stage_error_mode  = latch_d[MODE_DLY];
  assign stage_error_first = first_d[MODE_DLY] & latch_d[MODE_DLY];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      error_count        <= '0;
      error_sub_address  <= '0;
      error_phase        <= '0;
      error_phase_read   <= '0;
      error_fifo_depth   <= '0;
      error_update_latch <= 1'b0;
      error_frame_err    <= 1'b0;
      release_q          <= 1'b0;
      first_q            <= 1'b0;
      wr_vld_d           <= '0;
      latch_d            <= '0;
      first_d            <= '0;
    end else begin
      if (accept) begin
        if (stage_error_fst && (error_count != '0))
          error_frame_err <= 1'b1;

        if (stage_error_fst)
          error_count <= (error_tap_length == '0) ? '0 : CNT_W'(1);
        else if (error_finish)
          error_count <= '0;
        else
          error_count <= error_count + CNT_W'(1);

        if (stage_error_fst) begin
          error_sub_address <= (load_length == '0) ? '0 : CNT_W'(1);
        end else if (error_sub_address == load_length) begin
          error_sub_address <= '0;
          error_phase       <= next_phase(error_phase);
        end else begin
          error_sub_address <= error_sub_address + CNT_W'(1);
        end
      end

      // Simultaneous block completion and release cancel out.
      if (error_finish && !release_q)
        error_fifo_depth <= error_fifo_depth + DEPTH_W'(1);
      else if (!error_finish && release_q && (error_fifo_depth != '0))
        error_fifo_depth <= error_fifo_depth - DEPTH_W'(1);

      release_q <= error_update_mode & state_finish;

      if (state_finish)
        error_update_latch <= error_update_mode;

      first_q <= state_finish ? (error_update_mode & read_finish)
                              : (error_update_latch & read_finish);
      if (first_q)
        error_phase_read <= next_phase(error_phase_read);

      wr_vld_d[1] <= wr_address_vld;
      for (int i = 2; i <= WR_HOLD; i++) wr_vld_d[i] <= wr_vld_d[i-1];
      latch_d[1] <= error_update_latch;
      for (int i = 2; i <= LAT_LEN; i++) latch_d[i] <= latch_d[i-1];
      first_d[1] <= first_q;
      for (int i = 2; i <= MODE_DLY; i++) first_d[i] <= first_d[i-1];
    end
  end

endmodule
